alu_ctl_stage: RTL and testbench
================================

// Module: alu_ctl_stage
// PURPOSE
//  Registered, flow-controlled successor to the combinational ALU-control decoder. Decodes
//  {funct7,funct3,opcode} into a 5-bit ALU op, covering full RV32I ALU ops and optional M ops.
//  It also flags 16-bit parcels and illegal encodings.
//  Sits between the fetch/decode pipe register and the execute stage; a 2-entry skid buffer gives full throughput.
// PARAMETERS
//  TAG_W      4  width of sideband tag carried with each op (e.g. rd/ROB id)
//  EN_M       0  1 = decode funct7=0000001 on OP as MUL..REMU; 0 = flag them illegal
//  ILL_CNT_W  8  width of saturating illegal-op counter
// PORTS
//  clk        in   1        clock, all state rising-edge
//  rst_n      in   1        asynchronous active-low reset
//  flush      in   1        synchronous: drop all buffered entries
//  in_valid   in   1        upstream has an instruction
//  in_ready   out  1        stage can accept (registered)
//  opcode     in   7        instr[6:0]
//  funct3     in   3        instr[14:12]
//  funct7     in   7        instr[31:25]
//  in_tag     in   TAG_W    sideband, passed through unchanged
//  out_valid  out  1        decoded op available
//  out_ready  in   1        execute accepts
//  alu_op     out  5        alu_op_e code
//  is_c16     out  1        opcode[1:0]!=2'b11 (16-bit parcel)
//  illegal    out  1        unsupported/illegal encoding
//  out_tag    out  TAG_W    tag of current output entry
//  ill_count  out  ILL_CNT_W number of illegal ops accepted, saturating
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, alu_op=ALU_ADD, is_c16=0, illegal=0, out_tag=0, ill_count=0.
//  Handshake: transfer when valid&&ready on that side; in_* sampled on the accepting edge.
//   Output is valid exactly 1 cycle after acceptance into an empty stage. Output is held stable while out_valid&&!out_ready.
//  Buffer: 2 entries (main + skid), FIFO order. in_ready=0 iff both entries are full.
//   Full throughput of 1 op/cycle is sustained when out_ready=1.
//   Simultaneous accept+drain when full is impossible (in_ready=0). When 1 entry is held, accept+drain keeps count 1.
//  Decode (priority order, first match wins):
//   opcode[1:0]!=11                      -> ALU_ADD, is_c16=1
//   0010011 OP-IMM: f3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND
//   0010011 OP-IMM: f3 001 SLL (f7 must be 0); f3 101 SRL (f7=0) or SRA (f7=0100000)
//   0110011 OP f7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND
//   0110011 OP f7=0100000: f3 000 SUB, f3 101 SRA
//   0110011 OP f7=0000001, EN_M=1: f3 000..111 -> MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   0000011 / 0100011 / 0010111 / 1101111 / 1100111 (LOAD/STORE/AUIPC/JAL/JALR) -> ALU_ADD
//   0110111 LUI -> ALU_PASSB;   1100011 BRANCH -> ALU_SUB
//   anything else -> ALU_ILL with illegal=1, including OP/OP-IMM combos not listed above
//  ill_count: +1 on each accepted entry decoding illegal=1; saturates at all-ones, never wraps.
//   Counted at acceptance, so entries later flushed are still counted.
//  flush: next cycle out_valid=0, in_ready=1, and both entries are emptied.
//   Input presented in the flush cycle is not accepted. ill_count is not cleared.
//  rst_n asserted mid-operation: all entries are lost immediately (async), and outputs take their reset values.
// STRUCTURE
//  alu_ctl_pkg: typedef enum logic[4:0] alu_op_e
//   ADD=0,SUB=1,SLL=2,SLT=3,SLTU=4,XOR=5,SRL=6,SRA=7,OR=8,AND=9,
//   MUL=10,MULH=11,MULHSU=12,MULHU=13,DIV=14,DIVU=15,REM=16,REMU=17,PASSB=18,ILL=31
//  alu_ctl_pkg opcode constants: OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH
//  alu_ctl_pkg function: alu_decode(f7,f3,opc,en_m) returns {op,c16,ill}.
//  Sub-module alu_ctl_skid: generic 2-entry valid/ready skid buffer, parameter DATA_W,
//   holding {alu_op,is_c16,illegal,tag}. Decode sits combinationally ahead of it.
// TESTING
//  1 Reset then in 0000000_000_0010011 -> next cycle alu_op=0, out_valid=1, illegal=0.
//  2 OP 0100000_000/101 -> SUB(1)/SRA(7). OP-IMM 0100000_101 -> SRA. OP-IMM 0100000_001 -> ILL(31), illegal=1.
//  3 EN_M=0: 0000001_100_0110011 -> ILL, ill_count=1. EN_M=1: same input -> DIV(14), ill_count=0.
//  4 Stream 8 ops back-to-back, out_ready toggled 1,0,0,1...
//    -> in_ready falls after the 2nd stall. No loss or duplication; tags exit in order 0..7.
//  5 opcode=xxxxx01 -> is_c16=1, alu_op=0. With ILL_CNT_W=2, 5 illegal ops -> ill_count=3 (saturated).
//  6 Two entries held, then flush -> next cycle out_valid=0, in_ready=1.
//    Async rst_n pulse mid-stream -> outputs reset without a clock edge.

Source files
------------

// File: rtl/alu_ctl_pkg.sv
// alu_ctl_pkg: ALU op codes, RV32I opcode constants and the combinational ALU-control decoder
package alu_ctl_pkg;
  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3, ALU_SLTU = 5'd4,
    ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7, ALU_OR = 5'd8, ALU_AND = 5'd9,
    ALU_MUL = 5'd10, ALU_MULH = 5'd11, ALU_MULHSU = 5'd12, ALU_MULHU = 5'd13,
    ALU_DIV = 5'd14, ALU_DIVU = 5'd15, ALU_REM = 5'd16, ALU_REMU = 5'd17,
    ALU_PASSB = 5'd18, ALU_ILL = 5'd31
  } alu_op_e;

  typedef struct packed {
    alu_op_e op;
    logic    c16;
    logic    ill;
  } dec_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MUL     = 7'b0000001;

  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic dec_t alu_decode(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] opc, input logic en_m);
    alu_op_e op;
    op = ALU_ILL;
    if (opc[1:0] != 2'b11) op = ALU_ADD;
    else
      case (opc)
        OPC_OP_IMM:
          case (f3)
            3'b001:  op = f7 == F7_BASE ? ALU_SLL : ALU_ILL;
            3'b101:  op = f7 == F7_BASE ? ALU_SRL : f7 == F7_ALT ? ALU_SRA : ALU_ILL;
            default: op = base_op(f3);
          endcase
        OPC_OP:
          op = f7 == F7_BASE ? base_op(f3) :
               f7 == F7_ALT ? (f3 == 3'b000 ? ALU_SUB : f3 == 3'b101 ? ALU_SRA : ALU_ILL) :
               (f7 == F7_MUL && en_m) ? alu_op_e'(5'(ALU_MUL) + {2'b00, f3}) : ALU_ILL;
        OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL, OPC_JALR: op = ALU_ADD;
        OPC_LUI:    op = ALU_PASSB;
        OPC_BRANCH: op = ALU_SUB;
        default:    op = ALU_ILL;
      endcase
    return '{op: op, c16: opc[1:0] != 2'b11, ill: op == ALU_ILL};
  endfunction
endpackage

// File: rtl/alu_ctl_if.sv
// alu_ctl_if: upstream/downstream handshake and decoded-op bundle of the ALU-control stage
interface alu_ctl_if #(parameter int TAG_W = 4, parameter int ILL_CNT_W = 8);
  logic                    in_valid, in_ready, out_valid, out_ready, is_c16, illegal;
  logic [6:0]              opcode, funct7;
  logic [2:0]              funct3;
  logic [TAG_W-1:0]        in_tag, out_tag;
  alu_ctl_pkg::alu_op_e    alu_op;
  logic [ILL_CNT_W-1:0]    ill_count;
  modport master(output in_valid, opcode, funct3, funct7, in_tag, out_ready,
                 input in_ready, out_valid, alu_op, is_c16, illegal, out_tag, ill_count);
  modport slave(input in_valid, opcode, funct3, funct7, in_tag, out_ready,
                output in_ready, out_valid, alu_op, is_c16, illegal, out_tag, ill_count);
endinterface

// File: rtl/alu_ctl_skid.sv
// alu_ctl_skid: 2-entry valid/ready skid buffer (main + skid register), FIFO order
module alu_ctl_skid #(parameter int DATA_W = 8) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout
);
  logic              mv, sv;
  logic [DATA_W-1:0] md, sd;
  logic              push, pop;
  assign in_ready  = !sv;
  assign out_valid = mv;
  assign dout      = md;
  assign push      = in_valid && in_ready;
  assign pop       = mv && out_ready;
  // skid only fills while main is stalled, so sv implies mv and a full buffer never pushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= 1'b0;
      sv <= 1'b0;
      md <= '0;
      sd <= '0;
    end else if (flush) begin
      mv <= 1'b0;
      sv <= 1'b0;
    end else if (!mv || pop) begin
      mv <= sv || push;
      sv <= 1'b0;
      if (sv) md <= sd;
      else if (push) md <= din;
    end else if (push) begin
      sv <= 1'b1;
      sd <= din;
    end
  end
endmodule

// File: rtl/alu_ctl_stage.sv
// alu_ctl_stage: registered, flow-controlled ALU-control decode stage with illegal-op counter
module alu_ctl_stage import alu_ctl_pkg::*; #(
  parameter int TAG_W     = 4,
  parameter int EN_M      = 0,
  parameter int ILL_CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  alu_ctl_if.slave   bus
);
  localparam int DW = $bits(dec_t) + TAG_W;
  dec_t                 dec, dq;
  logic [DW-1:0]        dout;
  logic [ILL_CNT_W-1:0] cnt;
  logic                 push;
  assign dec  = alu_decode(bus.funct7, bus.funct3, bus.opcode, EN_M != 0);
  assign push = bus.in_valid && bus.in_ready && !flush;
  alu_ctl_skid #(.DATA_W(DW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .din       ({dec, bus.in_tag}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .dout      (dout)
  );
  assign dq            = dec_t'(dout[DW-1:TAG_W]);
  assign bus.alu_op    = dq.op;
  assign bus.is_c16    = dq.c16;
  assign bus.illegal   = dq.ill;
  assign bus.out_tag   = dout[TAG_W-1:0];
  assign bus.ill_count = cnt;
  // counted on acceptance so later-flushed entries still count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (push && dec.ill && !(&cnt)) cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_alu_ctl_stage.sv
// tb_alu_ctl_stage: directed + randomized check of two stage variants against a queue model
module tb_alu_ctl_stage;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [6:0] opcode = 0, funct7 = 0;
  logic [2:0] funct3 = 0;
  logic [3:0] in_tag = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_ctl_if #(.TAG_W(4), .ILL_CNT_W(8)) ia ();
  alu_ctl_if #(.TAG_W(4), .ILL_CNT_W(2)) ib ();
  assign ia.in_valid = in_valid;  assign ib.in_valid = in_valid;
  assign ia.opcode = opcode;      assign ib.opcode = opcode;
  assign ia.funct3 = funct3;      assign ib.funct3 = funct3;
  assign ia.funct7 = funct7;      assign ib.funct7 = funct7;
  assign ia.in_tag = in_tag;      assign ib.in_tag = in_tag;
  assign ia.out_ready = out_ready; assign ib.out_ready = out_ready;

  alu_ctl_stage #(.TAG_W(4), .EN_M(0), .ILL_CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ia.slave));
  alu_ctl_stage #(.TAG_W(4), .EN_M(1), .ILL_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ib.slave));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // reference decode written as lookup rules from the ISA tables
  function automatic int mop(bit [6:0] f7, bit [2:0] f3, bit [6:0] opc, bit en_m);
    int base[8];
    base = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (opc[1:0] != 2'b11) return 0;
    if (opc == 7'h13) begin
      if (f3 == 1) return f7 == 0 ? 2 : 31;
      if (f3 == 5) return f7 == 0 ? 6 : (f7 == 7'h20 ? 7 : 31);
      return base[f3];
    end
    if (opc == 7'h33) begin
      if (f7 == 0) return base[f3];
      if (f7 == 7'h20) return f3 == 0 ? 1 : (f3 == 5 ? 7 : 31);
      if (f7 == 1 && en_m) return 10 + int'(f3);
      return 31;
    end
    if (opc inside {7'h03, 7'h23, 7'h17, 7'h6f, 7'h67}) return 0;
    if (opc == 7'h37) return 18;
    if (opc == 7'h63) return 1;
    return 31;
  endfunction

  typedef struct { bit [6:0] f7; bit [2:0] f3; bit [6:0] opc; bit [3:0] tag; } ent_t;
  ent_t q[$];
  int cnt_a = 0, cnt_b = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cnt_a = 0;
      cnt_b = 0;
    end else if (flush) q.delete();
    else begin
      bit push;
      push = in_valid && q.size() < 2;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (push) begin
        q.push_back('{funct7, funct3, opcode, in_tag});
        if (mop(funct7, funct3, opcode, 0) == 31 && cnt_a < 255) cnt_a++;
        if (mop(funct7, funct3, opcode, 1) == 31 && cnt_b < 3) cnt_b++;
      end
    end
  end

  always @(posedge clk) begin
    ent_t e;
    int oa, ob;
    #1;
    chk("a_in_ready", ia.in_ready, q.size() < 2);
    chk("b_in_ready", ib.in_ready, q.size() < 2);
    chk("a_out_valid", ia.out_valid, q.size() > 0);
    chk("b_out_valid", ib.out_valid, q.size() > 0);
    chk("a_ill_count", ia.ill_count, cnt_a);
    chk("b_ill_count", ib.ill_count, cnt_b);
    if (q.size() > 0) begin
      e = q[0];
      oa = mop(e.f7, e.f3, e.opc, 0);
      ob = mop(e.f7, e.f3, e.opc, 1);
      chk("a_alu_op", ia.alu_op, oa);
      chk("b_alu_op", ib.alu_op, ob);
      chk("a_illegal", ia.illegal, oa == 31);
      chk("b_illegal", ib.illegal, ob == 31);
      chk("a_is_c16", ia.is_c16, e.opc[1:0] != 2'b11);
      chk("a_out_tag", ia.out_tag, e.tag);
      chk("b_out_tag", ib.out_tag, e.tag);
    end
  end

  task automatic put(input bit [6:0] f7, input bit [2:0] f3, input bit [6:0] opc, input bit [3:0] tag);
    funct7 = f7; funct3 = f3; opcode = opc; in_tag = tag; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  bit [6:0] opcs[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h17, 7'h6f, 7'h67, 7'h37, 7'h63};
  bit [6:0] f7s[3] = '{7'h00, 7'h20, 7'h01};

  task automatic rnd_fields();
    int k, j;
    k = $urandom_range(0, 9);
    j = $urandom_range(0, 3);
    opcode = k < 9 ? opcs[k] : 7'($urandom);
    funct7 = j < 3 ? f7s[j] : 7'($urandom);
    funct3 = 3'($urandom);
    in_tag = 4'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx, cyc;
    int tags[$];
    out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_in_ready", ia.in_ready, 1);
    chk("rst_alu_op", ia.alu_op, 0);
    chk("rst_is_c16", ia.is_c16, 0);
    chk("rst_illegal", ia.illegal, 0);
    chk("rst_out_tag", ia.out_tag, 0);
    chk("rst_ill_count", ia.ill_count, 0);
    rst_n = 1;
    @(negedge clk);
    put(7'h00, 3'd0, 7'h13, 4'd1);
    chk("t1_alu_op", ia.alu_op, 0);
    chk("t1_out_valid", ia.out_valid, 1);
    chk("t1_illegal", ia.illegal, 0);
    put(7'h01, 3'd4, 7'h33, 4'd2);
    chk("t3_a_op", ia.alu_op, 31);
    chk("t3_a_ill_count", ia.ill_count, 1);
    chk("t3_b_op", ib.alu_op, 14);
    chk("t3_b_ill_count", ib.ill_count, 0);
    put(7'h20, 3'd0, 7'h33, 4'd3);
    chk("t2_sub", ia.alu_op, 1);
    put(7'h20, 3'd5, 7'h33, 4'd4);
    chk("t2_sra", ia.alu_op, 7);
    put(7'h20, 3'd5, 7'h13, 4'd5);
    chk("t2_srai", ia.alu_op, 7);
    put(7'h20, 3'd1, 7'h13, 4'd6);
    chk("t2_ill_op", ia.alu_op, 31);
    chk("t2_ill_flag", ia.illegal, 1);
    put(7'h00, 3'd0, 7'h01, 4'd7);
    chk("t5_c16", ia.is_c16, 1);
    chk("t5_c16_op", ia.alu_op, 0);
    for (int i = 0; i < 5; i++) put(7'h00, 3'd0, 7'h7f, 4'(8 + i));
    chk("t5_b_sat", ib.ill_count, 3);
    chk("t5_a_count", ia.ill_count, 7);
    @(negedge clk);
    idx = 0;
    cyc = 0;
    while ((idx < 8 || ia.out_valid) && cyc < 100) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (ia.out_valid && out_ready) tags.push_back(int'(ia.out_tag));
      in_valid = idx < 8;
      funct7 = 7'h00; opcode = 7'h33; funct3 = 3'($urandom); in_tag = 4'(idx);
      if (cyc == 2) chk("t4_in_ready_fall", ia.in_ready, 0);
      if (in_valid && ia.in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 0;
    chk("t4_timeout", cyc < 100, 1);
    chk("t4_count", tags.size(), 8);
    for (int i = 0; i < tags.size(); i++) chk("t4_order", tags[i], i);
    out_ready = 0;
    put(7'h00, 3'd0, 7'h33, 4'd9);
    put(7'h00, 3'd7, 7'h13, 4'd10);
    chk("t6_full_in_ready", ia.in_ready, 0);
    chk("t6_full_valid", ia.out_valid, 1);
    chk("t6_full_tag", ia.out_tag, 9);
    flush = 1;
    in_valid = 1; opcode = 7'h7f;
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk("t6_flush_valid", ia.out_valid, 0);
    chk("t6_flush_ready", ia.in_ready, 1);
    chk("t6_flush_count", ia.ill_count, 7);
    for (int i = 0; i < 400; i++) begin
      rnd_fields();
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 31) == 0;
      @(negedge clk);
    end
    flush = 0; out_ready = 0; in_valid = 0;
    put(7'h00, 3'd0, 7'h33, 4'd1);
    put(7'h01, 3'd0, 7'h33, 4'd2);
    chk("rst2_pre_valid", ia.out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("rst2_out_valid", ia.out_valid, 0);
    chk("rst2_in_ready", ia.in_ready, 1);
    chk("rst2_alu_op", ia.alu_op, 0);
    chk("rst2_out_tag", ia.out_tag, 0);
    chk("rst2_a_count", ia.ill_count, 0);
    chk("rst2_b_count", ib.ill_count, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 50; i++) begin
      rnd_fields();
      in_valid = $urandom_range(0, 1) != 0;
      out_ready = $urandom_range(0, 1) != 0;
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
